branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  - IF-stage direct-mapped BTB with 2-bit saturating counters. Predicts taken/target for PCF
//    before the EX-stage branch decision resolves the branch.
//  - Carries each prediction through the D and E stages. Compares it against the EX-stage
//    outcome (BranchE, BrTargetE), raises MispredictE and supplies the redirect PC.
//  - Trains the table from that same resolution.
// PARAMETERS
//  ENTRY_BITS  6  log2(number of entries); index = PC[ENTRY_BITS+1:2], tag = PC[31:ENTRY_BITS+2]
// PORTS
//  clk          in   1   CPU clock, all state updates on posedge
//  rst          in   1   asynchronous, active-high reset
//  PCF          in   32  fetch PC (lookup address)
//  PredTakenF   out  1   prediction for PCF: taken
//  PredTargetF  out  32  predicted target for PCF (valid when PredTakenF=1)
//  StallD       in   1   hold D-stage prediction register
//  FlushD       in   1   clear D-stage prediction register
//  StallE       in   1   hold E-stage prediction register; suppress table update
//  FlushE       in   1   clear E-stage prediction register
//  PCE          in   32  PC of instruction in EX
//  IsBranchE    in   1   EX instruction is a conditional branch (BranchTypeE != NOBRANCH)
//  BranchE      in   1   actual outcome from branch decision logic
//  BrTargetE    in   32  actual branch target computed in EX
//  MispredictE  out  1   EX prediction was wrong; hazard unit flushes D/E and redirects
//  RedirectPCE  out  32  correct next PC when MispredictE=1
//  LookupCnt    out  32  (BTB_STATS_EN only) resolved branches counter
//  MispredCnt   out  32  (BTB_STATS_EN only) mispredictions counter
// BEHAVIOUR
//  Storage: 2^ENTRY_BITS entries, each {valid, tag, target[31:0], ctr[1:0]}. Held in flops, read combinationally.
//  Reset: all valid=0, ctr=2'b01; PredTakenD/E=0; PredTargetD/E=0.
//  Reset is asynchronous and may hit mid-operation: it discards all state immediately.
//  Lookup (0-cycle, combinational):
//   - hit = valid[idx] && tag[idx]==PCF tag.
//   - PredTakenF = hit && ctr[idx][1].
//   - PredTargetF = hit ? target[idx] : 32'h0.
//  Prediction pipeline (F->D, D->E on posedge):
//   - Flush has priority over Stall. Flush loads 0. Stall holds.
//   - Otherwise the register loads from the previous stage.
//  Resolution (combinational from E registers and EX inputs):
//   - IsBranchE=1: mispredict if PredTakenE!=BranchE, or (PredTakenE && BranchE && PredTargetE!=BrTargetE).
//   - IsBranchE=0 && PredTakenE=1: mispredict (alias/stale entry).
//   - RedirectPCE = (IsBranchE && BranchE) ? BrTargetE : PCE+4. Driven every cycle; meaningful only with MispredictE.
//  Update (posedge, only when StallE=0), using idx/tag of PCE:
//   - Hit and IsBranchE:
//     - ctr saturates up if BranchE, down otherwise (no wrap past 2'b11 / 2'b00).
//     - target <= BrTargetE if BranchE.
//   - Miss, IsBranchE && BranchE: allocate valid=1, tag, target=BrTargetE, ctr=2'b10. Replaces any occupant.
//   - Miss, IsBranchE && !BranchE: no allocation.
//   - !IsBranchE && PredTakenE: clear valid of that entry.
//  Simultaneous lookup and update of the same index: lookup returns pre-update contents (no bypass).
//  StallE=1: MispredictE still driven; table and counters unchanged, so one resolution trains exactly once.
// CONFIGURATION
//  BTB_STATS_EN defined:
//   - LookupCnt increments on each update cycle with IsBranchE=1.
//   - MispredCnt increments on each update cycle with MispredictE=1.
//   - Both reset to 0 and wrap modulo 2^32.
//  BTB_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. After rst, PCF=32'h0000_0040 -> PredTakenF=0, PredTargetF=0.
//  2. PCE=32'h40, IsBranchE=1, BranchE=1, BrTargetE=32'h80, StallE=0:
//     - that cycle: MispredictE=1, RedirectPCE=32'h80.
//     - next cycle: PCF=32'h40 -> PredTakenF=1, PredTargetF=32'h80.
//  3. Same branch resolves not-taken twice:
//     - ctr 10->01->00; PredTakenF=0 after the first.
//     - each time MispredictE=PredTakenE, RedirectPCE=32'h44.
//     - a third not-taken stays at 00.
//  4. Entry at 32'h40 predicted taken in E, IsBranchE=0:
//     - MispredictE=1, RedirectPCE=32'h44.
//     - entry invalidated; next lookup of 32'h40 misses.
//  5. Hold a resolving branch in E with StallE=1 for 3 cycles, then release:
//     - ctr changes once only.
//     - BTB_STATS_EN: LookupCnt +1 only.
//  6. FlushE=1 together with StallE=1: PredTakenE=0 next cycle. Async rst mid-run: all entries invalid at once.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
// Fetch/execute-side signal bundle for the branch target predictor.
// Optional statistics counters appear only when BTB_STATS_EN is defined.
interface branch_target_predictor_if;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        StallD;
    logic        FlushD;
    logic        StallE;
    logic        FlushE;
    logic [31:0] PCE;
    logic        IsBranchE;
    logic        BranchE;
    logic [31:0] BrTargetE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;
`ifdef BTB_STATS_EN
    logic [31:0] LookupCnt;
    logic [31:0] MispredCnt;
`endif

    // Pipeline/hazard side drives lookups, stalls and EX resolution.
    modport master (
`ifdef BTB_STATS_EN
        input  LookupCnt, MispredCnt,
`endif
        output PCF, StallD, FlushD, StallE, FlushE,
        output PCE, IsBranchE, BranchE, BrTargetE,
        input  PredTakenF, PredTargetF, MispredictE, RedirectPCE
    );

    modport slave (
`ifdef BTB_STATS_EN
        output LookupCnt, MispredCnt,
`endif
        input  PCF, StallD, FlushD, StallE, FlushE,
        input  PCE, IsBranchE, BranchE, BrTargetE,
        output PredTakenF, PredTargetF, MispredictE, RedirectPCE
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters, prediction carried F->D->E and resolved in EX.
// Define BTB_STATS_EN to add resolved-branch and misprediction counters.
module branch_target_predictor #(
    parameter int ENTRY_BITS = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    branch_target_predictor_if.slave   bus
);
    localparam int ENTRIES = 1 << ENTRY_BITS;
    localparam int TAG_W   = 30 - ENTRY_BITS;

    typedef logic [ENTRY_BITS-1:0] idx_t;
    typedef logic [TAG_W-1:0]      tag_t;

    typedef struct packed {
        logic        valid;
        tag_t        tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: 32'h0, ctr: 2'b01};

    entry_t      tbl_q [ENTRIES];
    entry_t      tbl_d [ENTRIES];
    logic        pred_taken_d_q,  pred_taken_d_d;
    logic [31:0] pred_target_d_q, pred_target_d_d;
    logic        pred_taken_e_q,  pred_taken_e_d;
    logic [31:0] pred_target_e_q, pred_target_e_d;

    idx_t idx_f, idx_e;
    tag_t tag_f, tag_e;
    logic hit_f, hit_e;
    logic mispredict;

    // Byte-offset bits of the PCs never participate in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.PCF[1:0], bus.PCE[1:0]};

    assign idx_f = bus.PCF[ENTRY_BITS+1:2];
    assign tag_f = bus.PCF[31:ENTRY_BITS+2];
    assign idx_e = bus.PCE[ENTRY_BITS+1:2];
    assign tag_e = bus.PCE[31:ENTRY_BITS+2];

    // Lookup sees pre-update contents even when EX trains the same index.
    assign hit_f           = tbl_q[idx_f].valid && (tbl_q[idx_f].tag == tag_f);
    assign hit_e           = tbl_q[idx_e].valid && (tbl_q[idx_e].tag == tag_e);
    assign bus.PredTakenF  = hit_f && tbl_q[idx_f].ctr[1];
    assign bus.PredTargetF = hit_f ? tbl_q[idx_f].target : 32'h0;

    always_comb begin
        if (bus.IsBranchE) begin
            mispredict = (pred_taken_e_q != bus.BranchE) ||
                         (pred_taken_e_q && bus.BranchE && (pred_target_e_q != bus.BrTargetE));
        end else begin
            // A taken prediction for a non-branch means a stale or aliased entry.
            mispredict = pred_taken_e_q;
        end
    end

    assign bus.MispredictE = mispredict;
    assign bus.RedirectPCE = (bus.IsBranchE && bus.BranchE) ? bus.BrTargetE : bus.PCE + 32'd4;

    // Prediction pipeline: flush wins over stall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pred_taken_d_d  = pred_taken_d_q;
        pred_target_d_d = pred_target_d_q;
        pred_taken_e_d  = pred_taken_e_q;
        pred_target_e_d = pred_target_e_q;
        if (bus.FlushD) begin
            pred_taken_d_d  = 1'b0;
            pred_target_d_d = 32'h0;
        end else if (!bus.StallD) begin
            pred_taken_d_d  = bus.PredTakenF;
            pred_target_d_d = bus.PredTargetF;
        end
        if (bus.FlushE) begin
            pred_taken_e_d  = 1'b0;
            pred_target_e_d = 32'h0;
        end else if (!bus.StallE) begin
            pred_taken_e_d  = pred_taken_d_q;
            pred_target_e_d = pred_target_d_q;
        end
    end

    always_comb begin
        tbl_d = tbl_q;
        if (!bus.StallE) begin
            if (bus.IsBranchE) begin
                if (hit_e) begin
                    if (bus.BranchE) begin
                        if (tbl_q[idx_e].ctr != 2'b11) tbl_d[idx_e].ctr = tbl_q[idx_e].ctr + 2'b01;
                        tbl_d[idx_e].target = bus.BrTargetE;
                    end else if (tbl_q[idx_e].ctr != 2'b00) begin
                        tbl_d[idx_e].ctr = tbl_q[idx_e].ctr - 2'b01;
                    end
                end else if (bus.BranchE) begin
                    tbl_d[idx_e] = '{valid: 1'b1, tag: tag_e, target: bus.BrTargetE, ctr: 2'b10};
                end
            end else if (pred_taken_e_q) begin
                tbl_d[idx_e].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the table is reset in full because valid and ctr have defined reset values.
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= ENTRY_RESET;
            pred_taken_d_q  <= 1'b0;
            pred_target_d_q <= 32'h0;
            pred_taken_e_q  <= 1'b0;
            pred_target_e_q <= 32'h0;
        end else begin
            // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
            tbl_q           <= tbl_d;
            pred_taken_d_q  <= pred_taken_d_d;
            pred_target_d_q <= pred_target_d_d;
            pred_taken_e_q  <= pred_taken_e_d;
            pred_target_e_q <= pred_target_e_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookup_cnt_q,  lookup_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        lookup_cnt_d  = lookup_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (!bus.StallE) begin
            if (bus.IsBranchE) lookup_cnt_d  = lookup_cnt_q + 32'd1;
            if (mispredict)    mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_cnt_q  <= 32'h0;
            mispred_cnt_q <= 32'h0;
        end else begin
            lookup_cnt_q  <= lookup_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.LookupCnt  = lookup_cnt_q;
    assign bus.MispredCnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: expectations are queued as stimulus is
// driven and drained against DUT outputs on the falling edge.
module tb_branch_target_predictor;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_target_predictor_if bus ();

    branch_target_predictor #(.ENTRY_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {SIG_TAKEN, SIG_TARGET, SIG_MP, SIG_REDIR, SIG_LCNT, SIG_MCNT} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    exp_t        sb [$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_lookup;
    logic [31:0] exp_mispred;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic push(input string tag, input sig_e sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input sig_e sig);
        case (sig)
            SIG_TAKEN:  return {31'b0, bus.PredTakenF};
            SIG_TARGET: return bus.PredTargetF;
            SIG_MP:     return {31'b0, bus.MispredictE};
            SIG_REDIR:  return bus.RedirectPCE;
`ifdef BTB_STATS_EN
            SIG_LCNT:   return bus.LookupCnt;
            SIG_MCNT:   return bus.MispredCnt;
`endif
            default:    return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sig), e.val);
        end
    endtask

    task automatic idle_inputs();
        bus.PCF       = 32'h100;
        bus.StallD    = 1'b0;
        bus.FlushD    = 1'b0;
        bus.StallE    = 1'b0;
        bus.FlushE    = 1'b0;
        bus.PCE       = 32'h0;
        bus.IsBranchE = 1'b0;
        bus.BranchE   = 1'b0;
        bus.BrTargetE = 32'h0;
    endtask

    task automatic expect_lookup(input string tag, input logic taken, input logic [31:0] target);
        push({tag, "_taken"},  SIG_TAKEN,  {31'b0, taken});
        push({tag, "_target"}, SIG_TARGET, target);
    endtask

    task automatic resolve(input logic taken, input logic [31:0] target);
        bus.PCE       = 32'h40;
        bus.IsBranchE = 1'b1;
        bus.BranchE   = taken;
        bus.BrTargetE = target;
        push("redirect", SIG_REDIR, taken ? target : 32'h44);
    endtask

    task automatic lookup_40(input string tag, input logic taken, input logic [31:0] target);
        bus.PCF    = 32'h40;
        bus.FlushD = 1'b1;
        expect_lookup(tag, taken, target);
    endtask

    task automatic expect_stats(input string tag);
`ifdef BTB_STATS_EN
        push({tag, "_lookup_cnt"},  SIG_LCNT, exp_lookup);
        push({tag, "_mispred_cnt"}, SIG_MCNT, exp_mispred);
`endif
    endtask

    // One clock: check queued expectations plus MispredictE mid-cycle, then advance.
    task automatic cyc(input string tag, input logic exp_mp);
        push({tag, "_mp"}, SIG_MP, {31'b0, exp_mp});
        if (!bus.StallE) begin
            if (bus.IsBranchE) exp_lookup++;
            if (exp_mp)        exp_mispred++;
        end
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        exp_lookup  = 32'h0;
        exp_mispred = 32'h0;
        idle_inputs();
        rst     = 1'b1;
        bus.PCF = 32'h40;
        @(negedge clk);
        expect_lookup("reset_lookup", 1'b0, 32'h0);
        push("reset_mp", SIG_MP, 32'h0);
        expect_stats("reset");
        drain();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();

        // First taken resolution allocates with ctr=10.
        resolve(1'b1, 32'h80);
        cyc("alloc", 1'b1);
        lookup_40("alloc_lookup", 1'b1, 32'h80);
        cyc("alloc_lookup", 1'b0);

        // Carry the taken prediction into E, then resolve not-taken.
        bus.PCF = 32'h40;
        cyc("nt_fetch", 1'b0);
        cyc("nt_dstage", 1'b0);
        resolve(1'b0, 32'h0);
        lookup_40("no_bypass", 1'b1, 32'h80);
        bus.FlushE = 1'b1;
        cyc("nt1", 1'b1);
        lookup_40("ctr01", 1'b0, 32'h80);
        cyc("ctr01", 1'b0);
        resolve(1'b0, 32'h0);
        cyc("nt2", 1'b0);
        resolve(1'b0, 32'h0);
        cyc("nt3", 1'b0);
        lookup_40("sat_low", 1'b0, 32'h80);
        cyc("sat_low", 1'b0);

        // Climb back up and saturate at 11.
        resolve(1'b1, 32'h80);
        cyc("tk1", 1'b1);
        lookup_40("ctr01_up", 1'b0, 32'h80);
        cyc("ctr01_up", 1'b0);
        resolve(1'b1, 32'h80);
        cyc("tk2", 1'b1);
        lookup_40("ctr10_up", 1'b1, 32'h80);
        cyc("ctr10_up", 1'b0);
        resolve(1'b1, 32'h80);
        cyc("tk3", 1'b1);
        resolve(1'b1, 32'h80);
        cyc("tk4", 1'b1);
        resolve(1'b0, 32'h0);
        cyc("nt4", 1'b0);
        lookup_40("sat_high", 1'b1, 32'h80);
        cyc("sat_high", 1'b0);

        // Taken prediction reaching E on a non-branch invalidates the entry.
        bus.PCF = 32'h40;
        cyc("alias_fetch", 1'b0);
        cyc("alias_dstage", 1'b0);
        bus.PCE    = 32'h40;
        bus.FlushD = 1'b1;
        bus.FlushE = 1'b1;
        push("alias_redirect", SIG_REDIR, 32'h44);
        cyc("alias", 1'b1);
        lookup_40("alias_invalid", 1'b0, 32'h0);
        cyc("alias_invalid", 1'b0);

        // A stalled resolution trains exactly once on release.
        resolve(1'b1, 32'h90);
        cyc("realloc", 1'b1);
        bus.PCF = 32'h40;
        cyc("stall_fetch", 1'b0);
        cyc("stall_dstage", 1'b0);
        for (int i = 0; i < 3; i++) begin
            resolve(1'b0, 32'h0);
            bus.StallE = 1'b1;
            cyc("stall_hold", 1'b1);
        end
        resolve(1'b0, 32'h0);
        bus.FlushD = 1'b1;
        bus.FlushE = 1'b1;
        cyc("stall_release", 1'b1);
        lookup_40("stall_ctr01", 1'b0, 32'h90);
        cyc("stall_ctr01", 1'b0);
        resolve(1'b1, 32'h90);
        cyc("stall_tk", 1'b1);
        lookup_40("stall_ctr10", 1'b1, 32'h90);
        expect_stats("stats");
        cyc("stall_ctr10", 1'b0);

        // Flush beats stall in the E register; stall also blocks invalidation.
        bus.PCF = 32'h40;
        cyc("fs_fetch", 1'b0);
        cyc("fs_dstage", 1'b0);
        bus.StallE = 1'b1;
        bus.FlushE = 1'b1;
        cyc("fs_both", 1'b1);
        cyc("fs_after", 1'b0);
        lookup_40("fs_entry_kept", 1'b1, 32'h90);
        cyc("fs_entry_kept", 1'b0);

        // Asynchronous reset mid-cycle clears the table without a clock edge.
        bus.PCF = 32'h40;
        #2;
        rst = 1'b1;
        exp_lookup  = 32'h0;
        exp_mispred = 32'h0;
        #1;
        expect_lookup("async_rst", 1'b0, 32'h0);
        expect_stats("async_rst");
        drain();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        lookup_40("post_rst", 1'b0, 32'h0);
        cyc("post_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
